gf_pow_ctrl: RTL and testbench
==============================

Name: gf_pow_ctrl

Overview:
- Sequencer computing base^expo in GF(2^m) using one shared cl_modules instance (clock `clk`) as its only arithmetic engine.
- Right-to-left square-and-multiply; every field multiply is two cl_modules operations: carry-less multiply, then polynomial reduction.
- Sits between a software or host request port and the cl_modules op_enable/op_finish handshake.

Parameters:
- DATA_WIDTH, 32, operand width of cl_modules and of base/expo/result.
- MAX_GF, 16, largest field degree m accepted; reduction is valid only up to this degree.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- m  in  $clog2(DATA_WIDTH)+1  field degree
- poly  in  DATA_WIDTH+1  irreducible polynomial, bit m set
- base  in  DATA_WIDTH  field element; bits >= m are masked to 0 at capture
- expo  in  DATA_WIDTH  exponent, unsigned
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at completion
- err  out  1  valid with done; high means m < 2 or m > MAX_GF
- result  out  DATA_WIDTH  base^expo mod poly; held until next accepted start
- op_enable  out  1  cl_modules request
- op_finish  in  1  cl_modules completion
- sum_funct, exp_funct, red_funct, carry_option  out  1 each  cl_modules function select
- in_width  out  $clog2(DATA_WIDTH)+1  set to captured m
- polyn_red_in  out  DATA_WIDTH+1  set to captured poly
- in_a, in_b  out  DATA_WIDTH  multiplier operands
- reduc_in  out  2*DATA_WIDTH  product to reduce
- out_mult  in  2*DATA_WIDTH  cl_modules product
- out_poly  in  DATA_WIDTH  cl_modules reduced result

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy, done, err, op_enable, all funct bits = 0.
  - result, in_a, in_b, reduc_in, in_width, polyn_red_in = 0.
  - Reset mid-operation aborts at once: op_enable drops the same edge and no done is issued.
- Registered state: r (accumulator), b (running square), e (remaining exponent), p (product latch).
- States: IDLE, CHECK, MUL_R, RED_R, SQ, RED_B, FIN.
- IDLE:
  - start=1 captures m, poly, masked base and expo.
  - If m illegal: FIN with err=1, result=0.
  - Else if expo==0: FIN with result=1.
  - Else r=1, b=base, e=expo, go to CHECK.
- CHECK (1 cycle): e[0]=1 goes to MUL_R; otherwise goes to SQ.
- MUL_R:
  - Drives op_enable=1, sum/exp/red/carry_option=0, in_a=r, in_b=b.
  - On op_finish=1, latch p=out_mult and go to RED_R.
- RED_R:
  - Drives red_funct=1, carry_option=0, reduc_in=p, in_width=m, polyn_red_in=poly.
  - On op_finish, r=out_poly.
  - If (e>>1)==0, go to FIN; else go to SQ.
- SQ: same as MUL_R with in_a=in_b=b; then RED_B.
- RED_B: reduction of the square; on op_finish, b=out_poly, e=e>>1, go to CHECK.
- FIN: result=r (or the error/zero-exponent value), done=1 for one cycle, busy=0, go to IDLE.
- cl_modules handshake:
  - op_enable and operands stay stable from issue until the cycle op_finish=1 is sampled.
  - op_enable is then 0 for at least one cycle before the next issue, so back-to-back ops never merge.
  - op_finish while op_enable=0 is ignored.
- start while busy is ignored. done and start in the same cycle: start is not accepted (state is FIN, not IDLE).
- Field element widths are m bits; r and b upper bits are always 0.
- Operation count for nonzero expo: (number of set bits) × 2 + (bit length of expo − 1) × 2. The final square is skipped.
- Latency is the sum of cl_modules op latencies, plus 1 idle cycle per op, plus 1 cycle per CHECK, plus 2 cycles (capture and FIN).

Optional Feature:
- GF_POW_OPCNT_EN
- Defined: adds output op_count [15:0].
  - Cleared on accepted start.
  - Increments once per cl_modules operation completed (op_finish sampled while op_enable=1).
  - Holds its value after done; reset value is 0.
- Undefined: no op_count port and no counter logic; all other behaviour is identical.

Test Plan:
- m=4, poly=19, base=2, expo=4 -> result=3, err=0; with GF_POW_OPCNT_EN, op_count=6.
- m=4, poly=19, base=2, expo=15 -> result=1 (generator order 15).
- m=8, poly=285, base=2, expo=8 -> result=29; expo=0 -> result=1 with no op_enable pulse; base=0, expo=5 -> result=0.
- m=1, or m=17 with MAX_GF=16 -> done within 2 cycles, err=1, result=0, op_enable never asserted.
- rst_n=0 for one cycle while RED_B is active (m=16, poly=69643, expo=0xFFFF) -> next cycle state IDLE, op_enable=0, busy=0, no done. A new start then completes correctly.
- start pulsed again while busy, and op_finish injected while op_enable=0 -> both ignored; result matches a software square-and-multiply model over 100 random (m=2..16, table poly, base, expo) cases.

Source files
------------

// File: rtl/gf_pow_ctrl_if.sv
// gf_pow_ctrl_if: request/response bus between the gf_pow_ctrl sequencer
// (master) and the shared cl_modules arithmetic engine (slave).
interface gf_pow_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: the master raises op_enable with the operands and function
  // select already valid. All of them stay stable until the master samples
  // op_finish=1. The slave signals completion with a one-cycle op_finish and
  // drives out_mult/out_poly in that same cycle. The master drops op_enable
  // on the edge that samples op_finish. It then keeps op_enable low for at
  // least one cycle before the next request, so successive ops never merge.
  // An op_finish seen while op_enable is low carries no meaning.
  logic                          op_enable;
  logic                          op_finish;
  logic                          sum_funct;
  logic                          exp_funct;
  logic                          red_funct;
  logic                          carry_option;
  logic [$clog2(DATA_WIDTH):0]   in_width;
  logic [DATA_WIDTH:0]           polyn_red_in;
  logic [DATA_WIDTH-1:0]         in_a;
  logic [DATA_WIDTH-1:0]         in_b;
  logic [2*DATA_WIDTH-1:0]       reduc_in;
  logic [2*DATA_WIDTH-1:0]       out_mult;
  logic [DATA_WIDTH-1:0]         out_poly;

  modport master (
    output op_enable, sum_funct, exp_funct, red_funct, carry_option,
    output in_width, polyn_red_in, in_a, in_b, reduc_in,
    input  op_finish, out_mult, out_poly
  );

  modport slave (
    input  op_enable, sum_funct, exp_funct, red_funct, carry_option,
    input  in_width, polyn_red_in, in_a, in_b, reduc_in,
    output op_finish, out_mult, out_poly
  );
endinterface

// File: rtl/gf_pow_ctrl.sv
// gf_pow_ctrl: computes base^expo in GF(2^m) by right-to-left
// square-and-multiply. Each field multiply is a carry-less multiply followed
// by a polynomial reduction, both issued to one shared cl_modules engine.
// Optional build macro GF_POW_OPCNT_EN adds the op_count output, which
// counts the engine operations completed since the last accepted start.
module gf_pow_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_GF     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(DATA_WIDTH):0] m,
  input  logic [DATA_WIDTH:0]         poly,
  input  logic [DATA_WIDTH-1:0]       base,
  input  logic [DATA_WIDTH-1:0]       expo,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [DATA_WIDTH-1:0]       result,
  output logic [2:0]                  state_dbg,
  gf_pow_ctrl_if.master               cl
`ifdef GF_POW_OPCNT_EN
  ,
  output logic [15:0]                 op_count
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int MW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL_R = 3'd2,
    S_RED_R = 3'd3,
    S_SQ    = 3'd4,
    S_RED_B = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   r_q, r_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   e_q, e_d;
  logic [2*DW-1:0] p_q, p_d;
  logic [DW-1:0]   result_q, result_d;
  logic            err_q, err_d;
  logic            op_en_q, op_en_d;
  logic            red_funct_q, red_funct_d;
  logic [DW-1:0]   in_a_q, in_a_d;
  logic [DW-1:0]   in_b_q, in_b_d;
  logic [2*DW-1:0] reduc_in_q, reduc_in_d;
  logic [MW-1:0]   in_width_q, in_width_d;
  logic [DW:0]     polyn_red_in_q, polyn_red_in_d;

  logic            m_legal;
  logic            op_done;
  logic            last_bit;
  logic [DW-1:0]   base_mask;

  assign m_legal  = (int'(m) >= 2) && (int'(m) <= MAX_GF);
  assign op_done  = op_en_q & cl.op_finish;
  assign last_bit = (e_q[DW-1:1] == '0);

  // Mask keeping only the low m bits of the incoming base element.
  always_comb begin
    base_mask = '0;
    for (int i = 0; i < DW; i++) begin
      base_mask[i] = (i < int'(m));
    end
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: each engine state advances only on its own op_finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (!m_legal || expo == '0) ? S_FIN : S_CHECK;
      S_CHECK: state_d = e_q[0] ? S_MUL_R : S_SQ;
      S_MUL_R: if (op_done) state_d = S_RED_R;
      S_RED_R: if (op_done) state_d = last_bit ? S_FIN : S_SQ;
      S_SQ:    if (op_done) state_d = S_RED_B;
      S_RED_B: if (op_done) state_d = S_CHECK;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy      = (state_q == S_CHECK) || (state_q == S_MUL_R) || (state_q == S_RED_R) ||
                (state_q == S_SQ)    || (state_q == S_RED_B);
    done      = (state_q == S_FIN);
    state_dbg = state_q;
  end

  // Datapath: first cycle in an engine state issues the op, which then holds
  // until op_finish; that first low cycle is the gap between back-to-back ops.
  always_comb begin
    r_d            = r_q;
    b_d            = b_q;
    e_d            = e_q;
    p_d            = p_q;
    result_d       = result_q;
    err_d          = err_q;
    op_en_d        = op_en_q;
    red_funct_d    = red_funct_q;
    in_a_d         = in_a_q;
    in_b_d         = in_b_q;
    reduc_in_d     = reduc_in_q;
    in_width_d     = in_width_q;
    polyn_red_in_d = polyn_red_in_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_width_d     = m;
          polyn_red_in_d = poly;
          err_d          = ~m_legal;
          r_d            = DW'(1);
          b_d            = base & base_mask;
          e_d            = expo;
          if (!m_legal)          result_d = '0;
          else if (expo == '0)   result_d = DW'(1);
        end
      end
      S_MUL_R, S_SQ: begin
        if (!op_en_q) begin
          op_en_d     = 1'b1;
          red_funct_d = 1'b0;
          in_a_d      = (state_q == S_MUL_R) ? r_q : b_q;
          in_b_d      = b_q;
        end else if (cl.op_finish) begin
          op_en_d = 1'b0;
          p_d     = cl.out_mult;
        end
      end
      S_RED_R, S_RED_B: begin
        if (!op_en_q) begin
          op_en_d     = 1'b1;
          red_funct_d = 1'b1;
          reduc_in_d  = p_q;
        end else if (cl.op_finish) begin
          op_en_d = 1'b0;
          if (state_q == S_RED_R) begin
            r_d = cl.out_poly;
            if (last_bit) result_d = cl.out_poly;
          end else begin
            b_d = cl.out_poly;
            e_d = e_q >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and engine-request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q            <= '0;
      b_q            <= '0;
      e_q            <= '0;
      p_q            <= '0;
      result_q       <= '0;
      err_q          <= 1'b0;
      op_en_q        <= 1'b0;
      red_funct_q    <= 1'b0;
      in_a_q         <= '0;
      in_b_q         <= '0;
      reduc_in_q     <= '0;
      in_width_q     <= '0;
      polyn_red_in_q <= '0;
    end else begin
      r_q            <= r_d;
      b_q            <= b_d;
      e_q            <= e_d;
      p_q            <= p_d;
      result_q       <= result_d;
      err_q          <= err_d;
      op_en_q        <= op_en_d;
      red_funct_q    <= red_funct_d;
      in_a_q         <= in_a_d;
      in_b_q         <= in_b_d;
      reduc_in_q     <= reduc_in_d;
      in_width_q     <= in_width_d;
      polyn_red_in_q <= polyn_red_in_d;
    end
  end

  assign result          = result_q;
  assign err             = err_q;
  assign cl.op_enable    = op_en_q;
  assign cl.sum_funct    = 1'b0;
  assign cl.exp_funct    = 1'b0;
  assign cl.carry_option = 1'b0;
  assign cl.red_funct    = red_funct_q;
  assign cl.in_a         = in_a_q;
  assign cl.in_b         = in_b_q;
  assign cl.reduc_in     = reduc_in_q;
  assign cl.in_width     = in_width_q;
  assign cl.polyn_red_in = polyn_red_in_q;

`ifdef GF_POW_OPCNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  // Operation counter: cleared by an accepted start, bumped per completed op.
  always_comb begin
    op_cnt_d = op_cnt_q;
    if (state_q == S_IDLE && start) op_cnt_d = '0;
    else if (op_done)               op_cnt_d = op_cnt_q + 16'd1;
  end

  // Operation counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) op_cnt_q <= '0;
    else        op_cnt_q <= op_cnt_d;
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_gf_pow_ctrl.sv
// tb_gf_pow_ctrl: bench for gf_pow_ctrl with a behavioural cl_modules engine
// (random latency, stray op_finish pulses) and a reference power model.
`timescale 1ns/1ps
module tb_gf_pow_ctrl;

  localparam int DW     = 32;
  localparam int MW     = $clog2(DW) + 1;
  localparam int MAX_GF = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [MW-1:0] m     = '0;
  logic [DW:0]   poly  = '0;
  logic [DW-1:0] base  = '0;
  logic [DW-1:0] expo  = '0;
  logic          busy, done, err;
  logic [DW-1:0] result;
  logic [2:0]    state_dbg;
`ifdef GF_POW_OPCNT_EN
  logic [15:0]   op_count;
`endif

  gf_pow_ctrl_if #(.DATA_WIDTH(DW)) cl_if ();

  gf_pow_ctrl #(.DATA_WIDTH(DW), .MAX_GF(MAX_GF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .m         (m),
    .poly      (poly),
    .base      (base),
    .expo      (expo),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .state_dbg (state_dbg),
    .cl        (cl_if)
`ifdef GF_POW_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;
  bit op_en_seen   = 0;

  logic [DW:0] exp_q[$];
`ifdef GF_POW_OPCNT_EN
  logic [15:0] cnt_q[$];
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic logic [63:0] clmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] acc = '0;
    for (int i = 0; i < DW; i++) if (b[i]) acc ^= ({32'd0, a} << i);
    return acc;
  endfunction

  function automatic logic [DW-1:0] reduce(input logic [63:0] x, input logic [DW:0] p, input int w);
    logic [63:0] v = x;
    for (int i = 63; i >= w; i--) if (v[i]) v ^= ({31'd0, p} << (i - w));
    return v[DW-1:0];
  endfunction

  // Bit-serial interleaved multiply, independent of the clmul+reduce path.
  function automatic logic [DW-1:0] gf_mul_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input int mm, input logic [DW:0] p);
    logic [DW:0] acc = '0;
    for (int i = mm - 1; i >= 0; i--) begin
      acc = acc << 1;
      if (acc[mm]) acc ^= p;
      if (b[i]) acc ^= {1'b0, a};
    end
    return acc[DW-1:0];
  endfunction

  // Left-to-right power; returns {err, result}.
  function automatic logic [DW:0] pow_ref(input int mm, input logic [DW:0] p,
                                          input logic [DW-1:0] bb, input logic [DW-1:0] ee);
    logic [DW-1:0] r = 1;
    logic [DW-1:0] bm;
    if (mm < 2 || mm > MAX_GF) return {1'b1, 32'd0};
    bm = bb & ((32'd1 << mm) - 32'd1);
    for (int i = DW - 1; i >= 0; i--) begin
      r = gf_mul_ref(r, r, mm, p);
      if (ee[i]) r = gf_mul_ref(r, bm, mm, p);
    end
    return {1'b0, r};
  endfunction

  function automatic logic [15:0] ops_ref(input logic [DW-1:0] ee);
    int bl = 0;
    if (ee == '0) return 16'd0;
    for (int i = 0; i < DW; i++) if (ee[i]) bl = i + 1;
    return 16'(2 * $countones(ee) + 2 * (bl - 1));
  endfunction

  function automatic logic [DW:0] poly_for(input int mm);
    case (mm)
      2:  return 33'h7;     3:  return 33'hB;     4:  return 33'h13;
      5:  return 33'h25;    6:  return 33'h43;    7:  return 33'h83;
      8:  return 33'h11D;   9:  return 33'h211;   10: return 33'h409;
      11: return 33'h805;   12: return 33'h1053;  13: return 33'h201B;
      14: return 33'h4443;  15: return 33'h8003;  default: return 33'h1100B;
    endcase
  endfunction

  // ---------------- cl_modules engine model ----------------
  int eng_cnt    = 0;
  bit eng_active = 0;
  initial begin
    cl_if.op_finish = 1'b0;
    cl_if.out_mult  = '0;
    cl_if.out_poly  = '0;
    forever begin
      @(negedge clk);
      cl_if.op_finish = 1'b0;
      if (cl_if.op_enable) begin
        if (!eng_active) begin
          eng_active = 1;
          eng_cnt    = $urandom_range(0, 2);
        end
        if (eng_cnt == 0) begin
          if (cl_if.red_funct)
            cl_if.out_poly = reduce(cl_if.reduc_in, cl_if.polyn_red_in, int'(cl_if.in_width));
          else
            cl_if.out_mult = clmul(cl_if.in_a, cl_if.in_b);
          cl_if.op_finish = 1'b1;
          eng_active      = 0;
        end else begin
          eng_cnt--;
        end
      end else begin
        eng_active = 0;
        if ($urandom_range(0, 7) == 0) begin
          cl_if.op_finish = 1'b1;
          cl_if.out_mult  = {$urandom(), $urandom()};
          cl_if.out_poly  = $urandom();
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW:0] exp_v;
    if (cl_if.op_enable) op_en_seen = 1;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check_val("err_result", {31'd0, err, result}, 64'(exp_v));
`ifdef GF_POW_OPCNT_EN
        check_val("op_count", 64'(op_count), 64'(cnt_q.pop_front()));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_case(input int mm, input logic [DW:0] pp, input logic [DW-1:0] bb,
                          input logic [DW-1:0] ee, input logic [DW:0] expv, input bit poke);
    int cyc;
    bit exp_ops;
    exp_ops = !expv[DW] && (ee != '0);
    @(negedge clk);
    m = MW'(mm); poly = pp; base = bb; expo = ee; start = 1'b1;
    op_en_seen = 0;
    exp_q.push_back(expv);
`ifdef GF_POW_OPCNT_EN
    cnt_q.push_back(expv[DW] ? 16'd0 : ops_ref(ee));
`endif
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 3000) begin
      if (poke && cyc == 3 && busy) begin
        start = 1'b1; m = MW'(5); base = '1; expo = 32'h3;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (!done) begin
      check_val("done_timeout", 64'(done), 64'd1);
      rst_n = 1'b0;
      exp_q.delete();
`ifdef GF_POW_OPCNT_EN
      cnt_q.delete();
`endif
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      if (expv[DW]) check_val("err_latency_le2", 64'(cyc <= 2), 64'd1);
      check_val("busy_at_done", 64'(busy), 64'd0);
      check_val("op_enable_seen", 64'(op_en_seen), 64'(exp_ops));
      // start held during the done cycle must be refused.
      m = MW'(mm); poly = pp; base = bb; expo = 32'h5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("done_one_cycle", 64'(done), 64'd0);
      check_val("start_in_fin_ignored", 64'(state_dbg), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int mm;
    logic [DW-1:0] bb, ee;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_state", 64'(state_dbg), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_result", 64'(result), 64'd0);
    check_val("rst_op_enable", 64'(cl_if.op_enable), 64'd0);
    check_val("rst_red_funct", 64'(cl_if.red_funct), 64'd0);
    check_val("rst_in_a_b", {cl_if.in_a, cl_if.in_b}, 64'd0);
    check_val("rst_reduc_in", cl_if.reduc_in, 64'd0);
    check_val("rst_width_poly", {25'd0, cl_if.in_width, cl_if.polyn_red_in}, 64'd0);
`ifdef GF_POW_OPCNT_EN
    check_val("rst_op_count", 64'(op_count), 64'd0);
`endif
    rst_n = 1'b1;

    run_case(4,  33'h13,    32'd2,    32'd4,      {1'b0, 32'd3},  1'b0);
    run_case(4,  33'h13,    32'd2,    32'd15,     {1'b0, 32'd1},  1'b0);
    run_case(8,  33'h11D,   32'd2,    32'd8,      {1'b0, 32'd29}, 1'b0);
    run_case(8,  33'h11D,   32'h55,   32'd0,      {1'b0, 32'd1},  1'b0);
    run_case(8,  33'h11D,   32'd0,    32'd5,      {1'b0, 32'd0},  1'b0);
    run_case(1,  33'h3,     32'd1,    32'd5,      {1'b1, 32'd0},  1'b0);
    run_case(17, 33'h20009, 32'd2,    32'd5,      {1'b1, 32'd0},  1'b0);
    run_case(4,  33'h13,    32'h12,   32'd4,      {1'b0, 32'd3},  1'b0);
    run_case(2,  33'h7,     32'd2,    32'd3,      {1'b0, 32'd1},  1'b0);
    run_case(16, 33'h1100B, 32'd1,    32'hFFFF,   {1'b0, 32'd1},  1'b1);

    // Reset while the square reduction is in flight.
    @(negedge clk);
    m = MW'(16); poly = 33'h1100B; base = 32'h1234; expo = 32'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!(state_dbg == 3'd5 && cl_if.op_enable) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("reach_red_b", 64'(state_dbg), 64'd5);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_state", 64'(state_dbg), 64'd0);
    check_val("abort_op_enable", 64'(cl_if.op_enable), 64'd0);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_case(16, 33'h1100B, 32'h1234, 32'hFFFF, pow_ref(16, 33'h1100B, 32'h1234, 32'hFFFF), 1'b0);

    for (int n = 0; n < 100; n++) begin
      mm = $urandom_range(2, 16);
      bb = $urandom();
      ee = $urandom() >> $urandom_range(0, 31);
      run_case(mm, poly_for(mm), bb, ee, pow_ref(mm, poly_for(mm), bb, ee), (n % 7) == 0);
    end

    repeat (3) @(negedge clk);
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
